// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the up/down counter slice.
package updown_counter_pkg;

    localparam int unsigned MaxWidth = 32;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } mode_e;

    // All-ones value for a given width; computed one bit wider so width == MaxWidth works.
    function automatic logic [MaxWidth-1:0] max_val(input int unsigned width);
        logic [MaxWidth:0] v;
        v = ((MaxWidth + 1)'(1) << width) - (MaxWidth + 1)'(1);
        return v[MaxWidth-1:0];
    endfunction

endpackage

// File: rtl/updown_counter_step.sv
// Combinational next-state and event logic for one counter step.
module updown_counter_step
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             increment,
    input  logic             decrement,
    input  mode_e            mode,
    output logic [WIDTH-1:0] count_next,
    output logic             overflow_next,
    output logic             underflow_next
);

    localparam logic [MaxWidth-1:0] MaxFull  = max_val(WIDTH);
    localparam logic [WIDTH-1:0]    MaxCount = MaxFull[WIDTH-1:0];

    always_comb begin
        count_next     = count;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (increment && !decrement) begin
            if (count == MaxCount) begin
                overflow_next = 1'b1;
                count_next    = (mode == MODE_SAT) ? count : '0;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end else if (decrement && !increment) begin
            if (count == '0) begin
                underflow_next = 1'b1;
                count_next     = (mode == MODE_SAT) ? count : MaxCount;
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with wrap or saturate mode, terminal flags and registered event pulses.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter bit          SATURATE    = 1'b0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [MaxWidth-1:0] MaxFull    = max_val(WIDTH);
    localparam logic [WIDTH-1:0]    MaxCount   = MaxFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    ResetCount = RESET_VALUE[WIDTH-1:0];
    localparam mode_e               Mode       = SATURATE ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    updown_counter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .count         (count_q),
        .increment     (increment),
        .decrement     (decrement),
        .mode          (Mode),
        .count_next    (count_d),
        .overflow_next (overflow_d),
        .underflow_next(underflow_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= ResetCount;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Flags decode only the register, so inputs never reach them combinationally.
    assign count     = count_q;
    assign at_max    = (count_q == MaxCount);
    assign at_zero   = (count_q == '0);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed table-driven bench covering wrap, saturate and non-zero reset-value instances.
module tb_updown_counter;

    logic clk = 1'b0;
    logic reset;
    logic w_inc, w_dec, s_inc, s_dec;
    logic [3:0] w_count, s_count, r_count;
    logic w_max, w_zero, w_ovf, w_unf;
    logic s_max, s_zero, s_ovf, s_unf;
    logic r_max, r_zero, r_ovf, r_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(0)) dut_wrap (
        .clk(clk), .reset(reset), .increment(w_inc), .decrement(w_dec),
        .count(w_count), .at_max(w_max), .at_zero(w_zero),
        .overflow(w_ovf), .underflow(w_unf)
    );

    updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(0)) dut_sat (
        .clk(clk), .reset(reset), .increment(s_inc), .decrement(s_dec),
        .count(s_count), .at_max(s_max), .at_zero(s_zero),
        .overflow(s_ovf), .underflow(s_unf)
    );

    updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(5)) dut_rv (
        .clk(clk), .reset(reset), .increment(1'b0), .decrement(1'b0),
        .count(r_count), .at_max(r_max), .at_zero(r_zero),
        .overflow(r_ovf), .underflow(r_unf)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       inc;
        logic       dec;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
        logic       amax;
        logic       azero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, take one edge, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wrap(input string name, input int cnt, input int ovf, input int unf);
        check({name, ".count"}, int'(w_count), cnt);
        check({name, ".overflow"}, int'(w_ovf), ovf);
        check({name, ".underflow"}, int'(w_unf), unf);
        check({name, ".at_max"}, int'(w_max), int'(cnt == 15));
        check({name, ".at_zero"}, int'(w_zero), int'(cnt == 0));
    endtask

    task automatic check_sat(input string name, input int cnt, input int ovf, input int unf);
        check({name, ".count"}, int'(s_count), cnt);
        check({name, ".overflow"}, int'(s_ovf), ovf);
        check({name, ".underflow"}, int'(s_unf), unf);
        check({name, ".at_max"}, int'(s_max), int'(cnt == 15));
        check({name, ".at_zero"}, int'(s_zero), int'(cnt == 0));
    endtask

    initial begin
        reset = 1'b0;
        w_inc = 1'b0; w_dec = 1'b0;
        s_inc = 1'b0; s_dec = 1'b0;

        //              name       rst   inc   dec   cnt     ovf   unf   max   zero
        vecs.push_back('{"rst",    1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"up1",    1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"up2",    1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"dn1",    1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"idle",   1'b0, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"up3",    1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"up4",    1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"both1",  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"both2",  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"both3",  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"both4",  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"both5",  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"dn2",    1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"dn3",    1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"dn4",    1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"wrapdn", 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"idle2",  1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"wrapup", 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"idle3",  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"up5",    1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rstinc", 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1});

        // Reset then idle, including the non-zero reset value instance.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_wrap("reset_wrap", 0, 0, 0);
        check_sat("reset_sat", 0, 0, 0);
        check("reset_rv.count", int'(r_count), 5);
        check("reset_rv.at_zero", int'(r_zero), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_wrap($sformatf("idle_%0d", i), 0, 0, 0);
        end
        check("idle_rv.count", int'(r_count), 5);

        // Table-driven vectors on the wrap instance.
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            w_inc = vecs[i].inc;
            w_dec = vecs[i].dec;
            tick();
            check({vecs[i].name, ".count"}, int'(w_count), int'(vecs[i].cnt));
            check({vecs[i].name, ".overflow"}, int'(w_ovf), int'(vecs[i].ovf));
            check({vecs[i].name, ".underflow"}, int'(w_unf), int'(vecs[i].unf));
            check({vecs[i].name, ".at_max"}, int'(w_max), int'(vecs[i].amax));
            check({vecs[i].name, ".at_zero"}, int'(w_zero), int'(vecs[i].azero));
        end
        reset = 1'b0; w_inc = 1'b0; w_dec = 1'b0;
        tick();

        // Wrap: 15 increments to max, then one more wraps with a single pulse.
        for (int k = 1; k <= 15; k++) begin
            w_inc = 1'b1;
            tick();
            check_wrap($sformatf("wrapup_%0d", k), k, 0, 0);
        end
        tick();
        check_wrap("wrap_to_zero", 0, 1, 0);
        tick();
        check_wrap("wrap_resume", 1, 0, 0);
        w_inc = 1'b0;
        tick();
        check_wrap("wrap_pulse_clear", 1, 0, 0);

        // Saturate: over-run both ends, pulse on each extra request.
        for (int k = 1; k <= 20; k++) begin
            s_inc = 1'b1;
            tick();
            check_sat($sformatf("satup_%0d", k), (k > 15) ? 15 : k, int'(k > 15), 0);
        end
        s_inc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            s_dec = 1'b1;
            tick();
            check_sat($sformatf("satdn_%0d", k), (k > 15) ? 0 : 15 - k, 0, int'(k > 15));
        end
        s_dec = 1'b0;
        tick();
        check_sat("sat_idle", 0, 0, 0);

        // Reset mid-count with increment held: to 0, then resumes 1, 2, 3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        w_inc = 1'b1;
        for (int k = 1; k <= 9; k++) tick();
        check_wrap("mid_pre", 9, 0, 0);
        reset = 1'b1;
        tick();
        check_wrap("mid_reset", 0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_wrap($sformatf("mid_resume_%0d", k), k, 0, 0);
        end
        w_inc = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Event pulses must never overlap on either instance.
    always @(negedge clk) begin
        if (w_ovf && w_unf) begin
            errors++;
            $display("FAIL wrap_pulse_overlap: got ovf=%0b unf=%0b expected not both", w_ovf, w_unf);
        end
        if (s_ovf && s_unf) begin
            errors++;
            $display("FAIL sat_pulse_overlap: got ovf=%0b unf=%0b expected not both", s_ovf, s_unf);
        end
    end

endmodule
